// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch widths, FSM state encoding and buffer entry type
package cpu_pkg;
   localparam int INST_W = 32;
   localparam int PC_W   = 64;
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_FULL = 2'd2
   } fetch_state_e;
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two FIFO with synchronous flush, full/empty flags and occupancy
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   // pointers and occupancy; flush discards everything regardless of push/pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_q + AW'(do_pop);
         wr_q  <= wr_q + AW'(do_push);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   // storage needs no reset: only slots below the occupancy are ever presented
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch FSM feeding a decode buffer; INST_FETCH_PERF_EN adds perf counters
module inst_fetch
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = 64'h0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_ce,
   output logic [PC_W-1:0]   rom_addr,
   input  logic              rom_valid,
   input  logic [INST_W-1:0] rom_inst,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [PC_W-1:0]   if_pc,
   output logic [INST_W-1:0] if_inst
`ifdef INST_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            run_q;
   logic            push, pop, empty, full;
   logic [CW-1:0]   cnt, cnt_nxt;
   fetch_entry_t    wr_entry, head;
   assign pop      = if_valid & if_ready;
   assign push     = (state_q == ST_WAIT) & rom_valid & ~redirect;
   assign cnt_nxt  = cnt + CW'(push) - CW'(pop);
   assign wr_entry = '{pc: pc_q, inst: rom_inst};
   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect),
      .push_i  (push),
      .pop_i   (if_ready),
      .data_i  (wr_entry),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (cnt)
   );
   // state, fetch pc and start-up flag; run_q holds off the first request until one edge after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         run_q   <= 1'b1;
      end
   end
   // next state and pc; redirect overrides any push or pop of the same cycle
   always_comb begin
      pc_d    = redirect ? redirect_pc : push ? pc_q + PC_W'(4) : pc_q;
      state_d = redirect ? ST_REQ
              : state_q == ST_REQ  ? (run_q ? ST_WAIT : ST_REQ)
              : state_q == ST_WAIT ? (push ? (cnt_nxt < CW'(FIFO_DEPTH) ? ST_REQ : ST_FULL) : ST_WAIT)
              : (~full | pop) ? ST_REQ : ST_FULL;
   end
   // ROM request and buffer head; head fields read as zero while the buffer is empty
   always_comb begin
      rom_ce   = run_q & (state_q != ST_FULL);
      rom_addr = pc_q >> 2;
      if_valid = ~empty;
      if_pc    = empty ? '0 : head.pc;
      if_inst  = empty ? '0 : head.inst;
   end
`ifdef INST_FETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_flush_q;
   // free-running wrapping event counters for pushes and redirects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_q + 32'(push);
         perf_flush_q <= perf_flush_q + 32'(redirect);
      end
   end
   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized scoreboard bench for inst_fetch against an expected PC-stream model
module tb_inst_fetch;
   localparam logic [63:0] RPC = 64'h100;
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 0, rst = 0, redirect = 0, if_ready = 0;
   logic        rom_ce, rom_valid, if_valid;
   logic [63:0] rom_addr, if_pc, redirect_pc = '0;
   logic [31:0] rom_inst, if_inst, junk = '0;
   logic        strb = 0, force_v = 0;
`ifdef INST_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

   int   tests = 0, fails = 0, pops = 0, cyc = 0, age = 0, perf_left = 0, mode = 3, base = 0;
   logic [63:0] prev_addr = '0;
   logic        prev_ce = 0;
   exp_t        exp_q[$];
   exp_t        e;
   logic        hold = 0;
   logic [63:0] hold_pc;
   logic [31:0] hold_inst;

   function automatic logic [31:0] rom_word(input logic [63:0] waddr);
      return (waddr[31:0] * 32'h9E37_79B1) ^ waddr[63:32] ^ 32'h1357_9BDF;
   endfunction

   assign rom_valid = strb | force_v;
   assign rom_inst  = rom_valid ? rom_word(rom_addr) : junk;

   inst_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_ce      (rom_ce),
      .rom_addr    (rom_addr),
      .rom_valid   (rom_valid),
      .rom_inst    (rom_inst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_pc       (if_pc),
      .if_inst     (if_inst)
`ifdef INST_FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // expected delivery stream: consecutive PCs from p, each carrying the ROM word at pc/4
   task automatic load_exp(input logic [63:0] p);
      logic [63:0] a;
      exp_q.delete();
      for (int i = 0; i < 512; i++) begin
         a = p + 64'(i) * 64'd4;
         exp_q.push_back('{pc: a, inst: rom_word(a >> 2)});
      end
   endtask

   task automatic wait_wait_state(input string name);
      for (int i = 0; i < 20 && !(rom_ce && age >= 1); i++) step();
      check(name, 64'(rom_ce && age >= 1), 64'd1);
   endtask

   // ROM responder: mode 0 random strobes, 1 every 4th cycle, 2 counted strobes on held addresses, 3 silent
   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      age = (rom_ce && prev_ce && rom_addr == prev_addr) ? age + 1 : 0;
      prev_ce = rom_ce;
      prev_addr = rom_addr;
      junk = $urandom;
      case (mode)
         0: strb = rom_ce && ($urandom_range(1) == 1);
         1: strb = rom_ce && (cyc % 4 == 0);
         2: begin
            strb = rom_ce && age >= 1 && perf_left > 0;
            if (strb) perf_left--;
         end
         default: strb = 0;
      endcase
   end

   // monitor: pops the scoreboard on every accepted head, checks stability under stall
   initial forever begin
      @(negedge clk);
      if (rst && !redirect && hold && if_valid) begin
         check("stall_pc", if_pc, hold_pc);
         check("stall_inst", 64'(if_inst), 64'(hold_inst));
      end
      hold = rst && !redirect && if_valid && !if_ready;
      hold_pc = if_pc;
      hold_inst = if_inst;
      if (rst && !redirect && if_valid && if_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: got pc %h expected no delivery", if_pc);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc", if_pc, e.pc);
            check("sb_inst", 64'(if_inst), 64'(e.inst));
            pops++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check("rst_ce", 64'(rom_ce), 0);
      check("rst_valid", 64'(if_valid), 0);
      check("rst_pc", if_pc, 0);
      check("rst_inst", 64'(if_inst), 0);
`ifdef INST_FETCH_PERF_EN
      check("rst_perf_fetch", 64'(perf_fetch_cnt), 0);
`endif
      // reset fetch with ROM valid every 4th cycle
      load_exp(RPC);
      if_ready = 1;
      mode = 1;
      rst = 1;
      check("ce_before_edge", 64'(rom_ce), 0);
      step();
      check("first_ce", 64'(rom_ce), 1);
      check("first_addr", rom_addr, 64'h40);
      repeat (60) step();
      check("reset_fetch_progress", 64'(pops >= 3), 1);
      // backpressure: buffer fills to exactly four entries
      if_ready = 0;
      mode = 0;
      repeat (40) step();
      check("full_ce", 64'(rom_ce), 0);
      check("full_valid", 64'(if_valid), 1);
      mode = 3;
      base = pops;
      if_ready = 1;
      repeat (10) step();
      check("drain_count", 64'(pops - base), 4);
      // refill, then random decode stalls around the full point
      mode = 0;
      if_ready = 0;
      for (int i = 0; i < 40 && rom_ce; i++) step();
      check("refill_full", 64'(rom_ce), 0);
      repeat (150) begin
         if_ready = $urandom_range(1) == 1;
         step();
      end
      // redirect coinciding with a ROM response in WAIT
      mode = 3;
      if_ready = 1;
      repeat (8) step();
      if_ready = 0;
      perf_left = 2;
      mode = 2;
      repeat (12) step();
      mode = 3;
      wait_wait_state("redir_wait_reached");
      check("pre_redirect_valid", 64'(if_valid), 1);
      force_v = 1;
      redirect = 1;
      redirect_pc = 64'h200;
      load_exp(64'h200);
      step();
      force_v = 0;
      redirect = 0;
      check("valid_after_redirect", 64'(if_valid), 0);
      check("addr_after_redirect", rom_addr, 64'h80);
      mode = 0;
      if_ready = 1;
      base = pops;
      repeat (30) step();
      check("redirect_progress", 64'(pops - base >= 2), 1);
      // back-to-back redirects: only the latest target counts
      redirect = 1;
      redirect_pc = 64'h300;
      step();
      redirect_pc = 64'h400;
      load_exp(64'h400);
      step();
      redirect = 0;
      check("b2b_addr", rom_addr, 64'h100);
      check("b2b_valid", 64'(if_valid), 0);
      repeat (40) begin
         if_ready = $urandom_range(1) == 1;
         step();
      end
      // pc wraps past 2^64
      redirect = 1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      load_exp(64'hFFFF_FFFF_FFFF_FFF8);
      step();
      redirect = 0;
      base = pops;
      repeat (80) begin
         if_ready = $urandom_range(1) == 1;
         step();
      end
      check("wrap_progress", 64'(pops - base >= 3), 1);
      // reset asserted while a response is pending
      mode = 3;
      if_ready = 1;
      repeat (8) step();
      if_ready = 0;
      perf_left = 2;
      mode = 2;
      repeat (12) step();
      mode = 3;
      wait_wait_state("rst_wait_reached");
      check("pre_reset_valid", 64'(if_valid), 1);
      #1;
      force_v = 1;
      rst = 0;
      #1;
      check("async_ce", 64'(rom_ce), 0);
      check("async_valid", 64'(if_valid), 0);
      check("async_pc", if_pc, 0);
      check("async_inst", 64'(if_inst), 0);
      load_exp(RPC);
      step();
      step();
      force_v = 0;
      rst = 1;
      step();
      check("restart_ce", 64'(rom_ce), 1);
      check("restart_addr", rom_addr, 64'h40);
      mode = 0;
      if_ready = 1;
      base = pops;
      repeat (40) step();
      check("restart_progress", 64'(pops - base >= 2), 1);
`ifdef INST_FETCH_PERF_EN
      // counters: ten pushes and two redirects from a fresh reset
      mode = 3;
      rst = 0;
      step();
      load_exp(RPC);
      step();
      rst = 1;
      base = pops;
      perf_left = 10;
      mode = 2;
      for (int i = 0; i < 300 && perf_left > 0; i++) step();
      repeat (10) step();
      mode = 3;
      check("perf_pops", 64'(pops - base), 10);
      redirect = 1;
      redirect_pc = 64'h500;
      load_exp(64'h500);
      step();
      redirect = 0;
      step();
      redirect = 1;
      redirect_pc = 64'h600;
      load_exp(64'h600);
      step();
      redirect = 0;
      step();
      check("perf_fetch", 64'(perf_fetch_cnt), 10);
      check("perf_flush", 64'(perf_flush_cnt), 2);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the byte PC fetched first after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the fetch buffer entry count (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rom_ce  output  1  instruction ROM enable / request active.
REQ-006 SHALL have port rom_addr  output  64  ROM word address, equal to fetch PC >> 2.
REQ-007 SHALL have port rom_valid  input  1  ROM data-valid strobe.
REQ-008 SHALL have port rom_inst  input  32  ROM read data.
REQ-009 SHALL have port redirect  input  1  flush and restart fetch at redirect_pc.
REQ-010 SHALL have port redirect_pc  input  64  new byte PC, 4-byte aligned.
REQ-011 SHALL have port if_valid  output  1  buffer head holds an instruction.
REQ-012 SHALL have port if_ready  input  1  decode accepts the head.
REQ-013 SHALL have port if_pc  output  64  byte PC of the head instruction.
REQ-014 SHALL have port if_inst  output  32  head instruction word.

Function
REQ-015 SHALL run FSM states REQ (first request cycle), WAIT (response pending), FULL (buffer full, no request).
REQ-016 SHALL hold rom_ce=1 and rom_addr stable in REQ and WAIT; rom_ce=0 in FULL.
REQ-017 SHALL ignore rom_valid in REQ, since the synchronous ROM needs one cycle with the address registered.
REQ-018 SHALL, in WAIT with rom_valid=1, push {pc, rom_inst} into the buffer and advance pc by 4 (modulo 2^64, wraps silently).
REQ-019 SHALL transition after a push to REQ if the buffer has space after that cycle's pop, otherwise to FULL.
REQ-020 SHALL transition FULL->REQ on the first cycle the buffer has a free entry.
REQ-021 SHALL present if_valid/if_pc/if_inst from the buffer head; the entry is popped on if_valid & if_ready.
REQ-022 SHALL allow a push and a pop in the same cycle, with count unchanged, including when the buffer is full.
REQ-023 SHALL keep if_pc/if_inst stable while if_valid=1 and if_ready=0.
REQ-024 SHALL, on redirect=1, empty the buffer, drop any pending response (the rom_valid of that cycle is not pushed), load pc=redirect_pc and enter REQ next cycle; redirect takes priority over push and pop.
REQ-025 SHALL drive if_valid=0 in the cycle after a redirect.
REQ-026 SHALL, on back-to-back redirects, use only the latest redirect_pc.
REQ-027 SHALL sustain a throughput of one instruction per ROM valid strobe when decode never stalls.

Reset
REQ-028 SHALL asynchronously force, while rst=0: pc=RESET_PC, state=REQ, buffer empty, if_valid=0, rom_ce=0, if_pc=0, if_inst=0.
REQ-029 SHALL assert rom_ce on the first rising edge after rst is deasserted, with rom_addr=RESET_PC>>2.
REQ-030 SHALL discard a response in flight when reset is asserted mid-operation; it is never pushed.

Configuration
REQ-031 SHALL, with INST_FETCH_PERF_EN defined, add output perf_fetch_cnt (32-bit, reset 0, +1 per push, wraps) and output perf_flush_cnt (32-bit, reset 0, +1 per redirect, wraps).
REQ-032 SHALL, without INST_FETCH_PERF_EN, omit both perf ports and their counters, with otherwise identical behaviour.

Structure
REQ-033 SHALL place the FSM state encoding, the 32-bit instruction width and the 64-bit PC width in shared package cpu_pkg.
REQ-034 SHALL implement the buffer as sub-module fetch_fifo (parameterised depth and width, synchronous flush, full/empty flags).

Verification
REQ-035 SHALL cover reset fetch: RESET_PC=64'h100, ROM valid every 4th cycle, if_ready=1 -> if_pc sequence 0x100, 0x104, 0x108 with the matching ROM words, and rom_addr starting at 0x40.
REQ-036 SHALL cover backpressure: if_ready=0 for 40 cycles with FIFO_DEPTH=4 -> exactly 4 entries buffered, rom_ce=0 in FULL, and no lost or duplicated PCs after release.
REQ-037 SHALL cover redirect coinciding with rom_valid: redirect_pc=0x200 -> the response is dropped, the buffer is emptied, and the next if_pc is 0x200.
REQ-038 SHALL cover simultaneous push and pop when full: count stays 4 and order is preserved.
REQ-039 SHALL cover reset asserted in WAIT: outputs reach their reset values immediately, and fetch restarts at RESET_PC.
REQ-040 SHALL cover the perf counters with INST_FETCH_PERF_EN defined: 10 pushes and 2 redirects -> perf_fetch_cnt=10 and perf_flush_cnt=2.
